// File: rtl/led_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_pkg : shared state type and defaults for the blink/fade path   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package led_pkg;

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    RAMP_UP   = 2'd1,
    ON        = 2'd2,
    RAMP_DOWN = 2'd3
  } led_state_t;

  localparam int DEF_PWM_BITS  = 8;
  localparam int DEF_STEP_CLKS = 195312;
  localparam int BOARD_CLK_HZ  = 100_000_000;

  // A one-clock step still needs a 1-bit counter.
  function automatic int step_cnt_width(input int step_clks);
    return (step_clks > 1) ? $clog2(step_clks) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_pwm_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_pwm_gen : free-running PWM counter with registered comparator  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module led_pwm_gen
  import led_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] level,
  output logic                pwm_o
);

  localparam logic [PWM_BITS-1:0] MAX_LEVEL = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] LAST_CNT  = MAX_LEVEL - 1'b1;

  logic [PWM_BITS-1:0] pwm_cnt;

  // Period is MAX_LEVEL clocks so that level=MAX_LEVEL is a solid 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      pwm_o   <= 1'b0;
    end else begin
      pwm_cnt <= (pwm_cnt == LAST_CNT) ? '0 : pwm_cnt + 1'b1;
      pwm_o   <= (pwm_cnt < level);
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_fade_driver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_fade_driver : turns blink edges into PWM fade-up/down ramps    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module led_fade_driver
  import led_pkg::*;
#(
  parameter int PWM_BITS  = DEF_PWM_BITS,
  parameter int STEP_CLKS = DEF_STEP_CLKS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                blink_in,
  output logic                led_out,
  output logic [PWM_BITS-1:0] level,
  output logic                busy
);

  localparam int                  STEP_W    = step_cnt_width(STEP_CLKS);
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_CLKS - 1);
  localparam logic [PWM_BITS-1:0] MAX_LEVEL = {PWM_BITS{1'b1}};

  led_state_t          state, state_nxt;
  logic                tgt;
  logic [PWM_BITS-1:0] level_nxt;
  logic [PWM_BITS-1:0] level_inc;
  logic [PWM_BITS-1:0] level_dec;
  logic [PWM_BITS-1:0] pwm_level;
  logic [STEP_W-1:0]   step_cnt, step_cnt_nxt;
  logic                step_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= OFF;
      level    <= '0;
      step_cnt <= '0;
      tgt      <= 1'b0;
    end else begin
      state    <= state_nxt;
      level    <= level_nxt;
      step_cnt <= step_cnt_nxt;
      tgt      <= blink_in;
    end
  end

  assign step_done = (step_cnt == STEP_LAST);
  assign level_inc = (level == MAX_LEVEL) ? MAX_LEVEL : level + 1'b1;
  assign level_dec = (level == '0) ? '0 : level - 1'b1;

  // Direction reversal is tested before the step so it wins a tie.
  always_comb begin
    state_nxt    = state;
    level_nxt    = level;
    step_cnt_nxt = step_cnt + 1'b1;
    if (!en) begin
      state_nxt    = OFF;
      level_nxt    = '0;
      step_cnt_nxt = '0;
    end else begin
      case (state)
        OFF: begin
          level_nxt    = '0;
          step_cnt_nxt = '0;
          if (tgt) state_nxt = RAMP_UP;
        end
        RAMP_UP: begin
          if (!tgt) begin
            state_nxt    = RAMP_DOWN;
            step_cnt_nxt = '0;
          end else if (step_done) begin
            level_nxt    = level_inc;
            step_cnt_nxt = '0;
            if (level_inc == MAX_LEVEL) state_nxt = ON;
          end
        end
        ON: begin
          level_nxt    = MAX_LEVEL;
          step_cnt_nxt = '0;
          if (!tgt) state_nxt = RAMP_DOWN;
        end
        RAMP_DOWN: begin
          if (tgt) begin
            state_nxt    = RAMP_UP;
            step_cnt_nxt = '0;
          end else if (step_done) begin
            level_nxt    = level_dec;
            step_cnt_nxt = '0;
            if (level_dec == '0) state_nxt = OFF;
          end
        end
        default: begin
          state_nxt    = OFF;
          level_nxt    = '0;
          step_cnt_nxt = '0;
        end
      endcase
    end
  end

  assign busy = (state == RAMP_UP) || (state == RAMP_DOWN);

  // Gating the compare input makes the pin go dark on the same edge as level.
  assign pwm_level = en ? level : '0;

  led_pwm_gen #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk  (clk),
    .rst_n(rst_n),
    .level(pwm_level),
    .pwm_o(led_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_led_fade_driver.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_led_fade_driver : self-checking bench, three step-rate variants |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_led_fade_driver;

  localparam int PWM_BITS = 4;
  localparam int MAXL     = 15;
  localparam int NINST    = 3;

  logic                clk = 1'b0;
  logic                rst_n_v [NINST];
  logic                en_v    [NINST];
  logic                blink_v [NINST];
  logic                led_v   [NINST];
  logic                busy_v  [NINST];
  logic [PWM_BITS-1:0] lvl_v   [NINST];

  int checks   = 0;
  int failures = 0;

  int mdl_level [NINST];
  int mdl_busy  [NINST];
  int mdl_led   [NINST];
  int mdl_pwm   [NINST];

  always #5 clk = ~clk;

  led_fade_driver #(.PWM_BITS(PWM_BITS), .STEP_CLKS(3)) dut (
    .clk(clk), .rst_n(rst_n_v[0]), .en(en_v[0]), .blink_in(blink_v[0]),
    .led_out(led_v[0]), .level(lvl_v[0]), .busy(busy_v[0]));

  led_fade_driver #(.PWM_BITS(PWM_BITS), .STEP_CLKS(1)) dut_fast (
    .clk(clk), .rst_n(rst_n_v[1]), .en(en_v[1]), .blink_in(blink_v[1]),
    .led_out(led_v[1]), .level(lvl_v[1]), .busy(busy_v[1]));

  led_fade_driver #(.PWM_BITS(PWM_BITS), .STEP_CLKS(200)) dut_slow (
    .clk(clk), .rst_n(rst_n_v[2]), .en(en_v[2]), .blink_in(blink_v[2]),
    .led_out(led_v[2]), .level(lvl_v[2]), .busy(busy_v[2]));

  // Reference: brightness moves one step toward the registered target every
  // s clocks; a changed target reverses the motion and restarts the step.
  typedef struct {
    int tgt;
    int level;
    int dir;
    int timer;
    int pwm;
    int led;
  } model_t;

  function automatic model_t model_reset();
    model_t r;
    r.tgt = 0; r.level = 0; r.dir = 0; r.timer = 0; r.pwm = 0; r.led = 0;
    return r;
  endfunction

  function automatic model_t model_step(model_t m, logic en, logic b, int s);
    model_t n;
    n = m;
    n.tgt = b ? 1 : 0;
    n.led = (en && (m.pwm < m.level)) ? 1 : 0;
    n.pwm = (m.pwm + 1) % MAXL;
    if (!en) begin
      n.level = 0; n.dir = 0; n.timer = 0;
    end else if (m.dir == 0) begin
      n.timer = 0;
      if (m.tgt == 1 && m.level < MAXL) n.dir = 1;
      else if (m.tgt == 0 && m.level > 0) n.dir = -1;
    end else if ((m.dir > 0) != (m.tgt == 1)) begin
      n.dir = -m.dir; n.timer = 0;
    end else if (m.timer + 1 >= s) begin
      n.timer = 0;
      n.level = m.level + m.dir;
      if (n.level <= 0)    begin n.level = 0;    n.dir = 0; end
      if (n.level >= MAXL) begin n.level = MAXL; n.dir = 0; end
    end else begin
      n.timer = m.timer + 1;
    end
    return n;
  endfunction

  generate
    for (genvar gi = 0; gi < NINST; gi++) begin : g_model
      localparam int S = (gi == 0) ? 3 : ((gi == 1) ? 1 : 200);
      model_t m;
      always @(posedge clk or negedge rst_n_v[gi]) begin
        if (!rst_n_v[gi]) m <= model_reset();
        else              m <= model_step(m, en_v[gi], blink_v[gi], S);
      end
      assign mdl_level[gi] = m.level;
      assign mdl_busy[gi]  = (m.dir != 0) ? 1 : 0;
      assign mdl_led[gi]   = m.led;
      assign mdl_pwm[gi]   = m.pwm;
    end
  endgenerate

  task automatic test_reset();
    for (int i = 0; i < NINST; i++) begin
      rst_n_v[i] = 1'b0; en_v[i] = 1'b1; blink_v[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < NINST; i++) begin
      checks++;
      if (lvl_v[i] !== 4'd0 || led_v[i] !== 1'b0 || busy_v[i] !== 1'b0) begin
        failures++;
        $display("FAIL reset_state[%0d]: got level=%0d led=%b busy=%b, expected 0/0/0",
                 i, lvl_v[i], led_v[i], busy_v[i]);
      end
      rst_n_v[i] = 1'b1;
    end
    blink_v[0] = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (lvl_v[0] !== 4'd6 || busy_v[0] !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_ramp: got level=%0d busy=%b, expected 6/1", lvl_v[0], busy_v[0]);
    end
    #2 rst_n_v[0] = 1'b0;
    #1;
    checks++;
    if (lvl_v[0] !== 4'd0 || led_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got level=%0d led=%b busy=%b, expected 0/0/0",
               lvl_v[0], led_v[0], busy_v[0]);
    end
    @(negedge clk);
    blink_v[0] = 1'b0;
    rst_n_v[0] = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_ramp();
    logic [3:0] exp_l;
    logic       exp_b;
    blink_v[0] = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      exp_l = (k < 2) ? 4'd0 : (((k - 2) / 3 > 15) ? 4'd15 : 4'((k - 2) / 3));
      exp_b = (k >= 2 && k <= 46);
      checks++;
      if (lvl_v[0] !== exp_l) begin
        failures++;
        $display("FAIL ramp_level k=%0d: got %0d expected %0d", k, lvl_v[0], exp_l);
      end
      checks++;
      if (busy_v[0] !== exp_b) begin
        failures++;
        $display("FAIL ramp_busy k=%0d: got %b expected %b", k, busy_v[0], exp_b);
      end
    end
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      checks++;
      if (led_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
        failures++;
        $display("FAIL on_solid k=%0d: got led=%b busy=%b expected 1/0", k, led_v[0], busy_v[0]);
      end
    end
  endtask

  task automatic test_reversal();
    int         waited;
    logic [3:0] exp_l;
    logic       exp_b;
    blink_v[0] = 1'b0;
    waited = 0;
    while ((lvl_v[0] !== 4'd0 || busy_v[0] !== 1'b0) && waited < 100) begin
      @(negedge clk); waited++;
    end
    blink_v[0] = 1'b1;
    waited = 0;
    while (lvl_v[0] !== 4'd7 && waited < 100) begin
      @(negedge clk); waited++;
    end
    checks++;
    if (lvl_v[0] !== 4'd7) begin
      failures++;
      $display("FAIL reversal_reach7: got %0d expected 7", lvl_v[0]);
    end
    blink_v[0] = 1'b0;
    for (int j = 1; j <= 26; j++) begin
      @(negedge clk);
      exp_l = (j < 5) ? 4'd7 : ((7 - (j - 2) / 3 < 0) ? 4'd0 : 4'(7 - (j - 2) / 3));
      exp_b = (j < 23);
      checks++;
      if (lvl_v[0] !== exp_l || busy_v[0] !== exp_b) begin
        failures++;
        $display("FAIL reversal j=%0d: got level=%0d busy=%b expected %0d/%b",
                 j, lvl_v[0], busy_v[0], exp_l, exp_b);
      end
    end
  endtask

  task automatic test_enable();
    int         waited;
    logic [3:0] exp_l;
    blink_v[0] = 1'b1;
    waited = 0;
    while ((lvl_v[0] !== 4'd15 || busy_v[0] !== 1'b0) && waited < 100) begin
      @(negedge clk); waited++;
    end
    @(negedge clk);
    checks++;
    if (lvl_v[0] !== 4'd15 || led_v[0] !== 1'b1) begin
      failures++;
      $display("FAIL enable_pre_on: got level=%0d led=%b expected 15/1", lvl_v[0], led_v[0]);
    end
    en_v[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (lvl_v[0] !== 4'd0 || led_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
        failures++;
        $display("FAIL enable_off k=%0d: got level=%0d led=%b busy=%b expected 0/0/0",
                 k, lvl_v[0], led_v[0], busy_v[0]);
      end
    end
    en_v[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      exp_l = 4'((k - 1) / 3);
      checks++;
      if (lvl_v[0] !== exp_l || busy_v[0] !== 1'b1) begin
        failures++;
        $display("FAIL enable_restart k=%0d: got level=%0d busy=%b expected %0d/1",
                 k, lvl_v[0], busy_v[0], exp_l);
      end
    end
    blink_v[0] = 1'b0;
  endtask

  task automatic test_step1();
    logic [3:0] exp_l;
    logic       exp_b;
    blink_v[1] = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      exp_l = (k < 2) ? 4'd0 : ((k - 2 > 15) ? 4'd15 : 4'(k - 2));
      exp_b = (k >= 2 && k <= 16);
      checks++;
      if (lvl_v[1] !== exp_l || busy_v[1] !== exp_b) begin
        failures++;
        $display("FAIL step1_up k=%0d: got level=%0d busy=%b expected %0d/%b",
                 k, lvl_v[1], busy_v[1], exp_l, exp_b);
      end
    end
    blink_v[1] = 1'b0;
    for (int j = 1; j <= 22; j++) begin
      @(negedge clk);
      exp_l = (j < 2) ? 4'd15 : ((15 - (j - 2) < 0) ? 4'd0 : 4'(15 - (j - 2)));
      exp_b = (j >= 2 && j <= 16);
      checks++;
      if (lvl_v[1] !== exp_l || busy_v[1] !== exp_b) begin
        failures++;
        $display("FAIL step1_down j=%0d: got level=%0d busy=%b expected %0d/%b",
                 j, lvl_v[1], busy_v[1], exp_l, exp_b);
      end
    end
  endtask

  task automatic test_pwm_duty();
    int   waited;
    int   highs;
    logic exp;
    blink_v[2] = 1'b1;
    waited = 0;
    while (lvl_v[2] !== 4'd5 && waited < 1500) begin
      @(negedge clk); waited++;
    end
    checks++;
    if (lvl_v[2] !== 4'd5) begin
      failures++;
      $display("FAIL duty_reach5: got %0d expected 5", lvl_v[2]);
    end
    waited = 0;
    do begin
      @(negedge clk); waited++;
    end while (mdl_pwm[2] != 1 && waited < 20);
    highs = 0;
    for (int n = 0; n < 45; n++) begin
      if (n > 0) @(negedge clk);
      exp = ((n % 15) < 5);
      checks++;
      if (led_v[2] !== exp) begin
        failures++;
        $display("FAIL duty_pattern n=%0d: got %b expected %b", n, led_v[2], exp);
      end
      if (led_v[2] === 1'b1) highs++;
    end
    checks++;
    if (highs != 15 || lvl_v[2] !== 4'd5) begin
      failures++;
      $display("FAIL duty_total: got highs=%0d level=%0d expected 15/5", highs, lvl_v[2]);
    end
    blink_v[2] = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < NINST; i++) begin
        checks++;
        if (int'(lvl_v[i]) !== mdl_level[i]) begin
          failures++;
          $display("FAIL rand_level[%0d] c=%0d: got %0d expected %0d", i, c, lvl_v[i], mdl_level[i]);
        end
        checks++;
        if (int'(busy_v[i]) !== mdl_busy[i]) begin
          failures++;
          $display("FAIL rand_busy[%0d] c=%0d: got %b expected %0d", i, c, busy_v[i], mdl_busy[i]);
        end
        checks++;
        if (int'(led_v[i]) !== mdl_led[i]) begin
          failures++;
          $display("FAIL rand_led[%0d] c=%0d: got %b expected %0d", i, c, led_v[i], mdl_led[i]);
        end
        if ($urandom_range(0, 24) == 0) blink_v[i] = ~blink_v[i];
        if (en_v[i] && $urandom_range(0, 79) == 0)       en_v[i] = 1'b0;
        else if (!en_v[i] && $urandom_range(0, 3) == 0)  en_v[i] = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_ramp();
    test_reversal();
    test_enable();
    test_step1();
    test_pwm_duty();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire

// File: doc/led_fade_driver.md
Name: led_fade_driver

Overview:
- Downstream consumer of the 1-bit blink output: turns its hard on/off edges into smooth fade-up/fade-down brightness ramps.
- Drives a physical LED pin via PWM.
- One instance per blink instance, placed between the blink generator and the board LED pin (led5/led6) in the top level.

Parameters:
- PWM_BITS, 8, brightness resolution; MAX_LEVEL = 2**PWM_BITS-1; PWM period = MAX_LEVEL clocks.
- STEP_CLKS, 195312, clocks per 1-LSB brightness step (full ramp ≈ 50,000,000 clocks at the 100 MHz board clock).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- en  input  1  driver enable; 0 forces LED dark.
- blink_in  input  1  target state from the blink stage (same clk domain); 1 = lit.
- led_out  output  1  PWM drive to LED pin, registered.
- level  output  PWM_BITS  current brightness, 0..MAX_LEVEL.
- busy  output  1  high while ramping.

Behaviour:
- Reset (async assert, sync release):
  - state=OFF; level=0, pwm_cnt=0, step_cnt=0, target register=0.
  - led_out=0, busy=0.
- blink_in is registered once (tgt); all decisions use tgt. An input change therefore reaches the FSM 1 cycle later.
- FSM states and transitions:
  - OFF: level=0. If tgt=1 → RAMP_UP.
  - RAMP_UP:
    - step_cnt counts 0..STEP_CLKS-1. At STEP_CLKS-1, level+1 and step_cnt→0.
    - When level becomes MAX_LEVEL → ON.
    - If tgt=0 at any cycle → RAMP_DOWN from the current level: no jump, step_cnt→0.
  - ON: level=MAX_LEVEL. If tgt=0 → RAMP_DOWN.
  - RAMP_DOWN:
    - Mirror of RAMP_UP: level-1 per step; level reaching 0 → OFF.
    - If tgt=1 → RAMP_UP from the current level, step_cnt→0.
- step_cnt is cleared on every state change. A step and a direction reversal in the same cycle: the reversal wins and there is no level change that cycle.
- Level arithmetic saturates: never wraps below 0 or above MAX_LEVEL.
- en=0 (synchronous, highest priority):
  - state=OFF, level=0, step_cnt=0, led_out=0 on the next edge.
  - tgt is still sampled.
  - On en returning to 1 with tgt=1, the driver ramps up from 0.
- busy = (state==RAMP_UP || state==RAMP_DOWN), combinational from state.
- PWM:
  - pwm_cnt free-runs 0..MAX_LEVEL-1, then wraps to 0.
  - led_out <= (pwm_cnt < level), giving 1 cycle latency from the counter/level to the pin.
  - level=0 → constant 0; level=MAX_LEVEL → constant 1.
  - Duty = level/MAX_LEVEL.
- Widths:
  - step_cnt width = $clog2(STEP_CLKS), with a minimum of 1.
  - pwm_cnt and level are PWM_BITS wide.
- STEP_CLKS=1 is legal: one level step per clock.

Decomposition:
- Shared package led_pkg:
  - state enum {OFF, RAMP_UP, ON, RAMP_DOWN} (2 bits).
  - Default PWM_BITS and STEP_CLKS constants.
  - Board clock frequency constant (100_000_000), shared with the blink stage.
- One sub-module, led_pwm_gen: pwm_cnt plus compare register. Parameter PWM_BITS; ports clk, rst_n, level, pwm_o.
- FSM and step timer stay in led_fade_driver.

Test Plan (PWM_BITS=4, MAX_LEVEL=15, STEP_CLKS=3, unless noted):
- Reset mid-ramp:
  - Stimulus: en=1, blink_in=1 for 20 cycles, then assert rst_n=0 asynchronously between edges.
  - Required: level=0, led_out=0, busy=0 immediately, without waiting for a clock edge.
- Full ramp up:
  - Stimulus: en=1, blink_in 0→1.
  - Required: busy rises 2 cycles after the input edge. Level increments every 3 cycles, reaching 15 after 45 ramp cycles. Then busy=0 and led_out stays constantly 1 over a 15-cycle window.
- Reversal mid-ramp:
  - Stimulus: ramp up to level=7, then drop blink_in.
  - Required: level holds at 7 for the reversal step, then 6, 5, … every 3 cycles, reaching 0 and OFF with no jump.
- PWM duty:
  - Stimulus: hold at level=5 (STEP_CLKS large, blink_in pulse timed).
  - Required: led_out high exactly 5 of every 15 cycles, contiguous, one cycle after pwm_cnt=0.
- Enable override:
  - Stimulus: at ON, drive en=0.
  - Required: next edge gives level=0, led_out=0, state OFF.
  - Then drive en=1 with blink_in=1: ramp restarts from level 0.
- Edge parameters (STEP_CLKS=1):
  - Stimulus: blink_in 0→1.
  - Required: level increments every cycle, 0→15 in 15 cycles, no overshoot past 15. When held low, no underflow below 0.
